// File: rtl/lfsr_parity_pkg.sv
// Shared widths, reset seed, feedback taps and helpers for the lfsr_parity block.
// Build option: define LFSR_PARITY_ODD_EN for odd parity over the output word.
package lfsr_parity_pkg;

    localparam int unsigned LFSR_WIDTH = 7;
    localparam int unsigned OUT_WIDTH  = LFSR_WIDTH + 1;

    typedef logic [LFSR_WIDTH-1:0] lfsr_state_t;

    // Output word: parity on top, LFSR state below.
    typedef struct packed {
        logic        parity;
        lfsr_state_t state;
    } lfsr_word_t;

    localparam lfsr_state_t LFSR_SEED = 7'h01;
    localparam lfsr_state_t LFSR_TAPS = 7'h60;

    // Feedback bit: XOR of the tapped state bits (x^7 + x^6 + 1).
    function automatic logic lfsr_feedback(input lfsr_state_t s);
        return ^(s & LFSR_TAPS);
    endfunction

    // Parity bit appended to the state so the whole word has the chosen parity.
    function automatic logic parity_bit(input lfsr_state_t s);
`ifdef LFSR_PARITY_ODD_EN
        return ~(^s);
`else
        return ^s;
`endif
    endfunction

endpackage

// File: rtl/lfsr_parity_if.sv
// Output bus of the lfsr_parity block: one 8-bit word per clock.
interface lfsr_parity_if;
    import lfsr_parity_pkg::*;

    logic [OUT_WIDTH-1:0] lfsr_out;

    modport master (output lfsr_out);
    modport slave  (input  lfsr_out);

endinterface

// File: rtl/lfsr_core.sv
// 7-bit maximal-length Fibonacci LFSR with seed reload and all-zero lock-up recovery.
module lfsr_core
    import lfsr_parity_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output lfsr_state_t state
);

    lfsr_state_t state_d;

    // Next state: shift in the feedback bit, or reseed if the register ever lands on zero.
    always_comb begin
        state_d = state;
        if (state == '0) begin
            state_d = LFSR_SEED;
        end else begin
            state_d = {state[LFSR_WIDTH-2:0], lfsr_feedback(state)};
        end
    end

    // State register with synchronous seed load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LFSR_SEED;
        end else begin
            state <= state_d;
        end
    end

endmodule

// File: rtl/lfsr_parity.sv
// LFSR pattern generator top: registered 7-bit state plus a parity bit in bit 7.
// Build option: LFSR_PARITY_ODD_EN selects odd parity (default even).
module lfsr_parity
    import lfsr_parity_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    lfsr_parity_if.master bus
);

    lfsr_state_t state;
    lfsr_word_t  word_c;

    lfsr_core u_core (
        .clk   (clk),
        .rst   (rst),
        .state (state)
    );

    // Parity derived directly from the registered state so it always matches the same cycle.
    always_comb begin
        word_c        = '0;
        word_c.state  = state;
        word_c.parity = parity_bit(state);
    end

    assign bus.lfsr_out = word_c;

endmodule

// File: tb/tb_lfsr_parity.sv
// Scoreboard bench for lfsr_parity: driver pushes expected words, monitor pops and compares.
module tb_lfsr_parity;

    logic clk;
    logic rst;

    lfsr_parity_if lif ();

    lfsr_parity dut (
        .clk (clk),
        .rst (rst),
        .bus (lif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;
    int pushes = 0;

    logic [7:0] exp_q [$];
    logic [7:0] obs_log [$];

    int m_state;

    // Reference: next state from the polynomial rule, using integer arithmetic.
    function automatic int model_next(input int s, input logic r);
        if (r || s == 0) return 1;
        return ((s * 2) % 128) + (((s / 64) + (s / 32)) % 2);
    endfunction

    // Reference: full word with parity chosen so the set-bit count of the word is even (odd when enabled).
    function automatic logic [7:0] model_word(input int s);
        logic [7:0] w;
        logic       p;
        w = 8'(s);
        p = ($countones(w) % 2) == 1;
`ifdef LFSR_PARITY_ODD_EN
        p = ~p;
`endif
        w[7] = p;
        return w;
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One clock: set rst ahead of the edge and push the word expected after it.
    task automatic step(input logic r);
        @(negedge clk);
        rst = r;
        m_state = model_next(m_state, r);
        exp_q.push_back(model_word(m_state));
        pushes++;
    endtask

    // Directed step: the expected state comes from a literal table instead of the model.
    task automatic step_lit(input int s);
        @(negedge clk);
        rst = 1'b0;
        m_state = model_next(m_state, 1'b0);
        exp_q.push_back(model_word(s));
        pushes++;
    endtask

    // Monitor: one word per clock, compared after the edge.
    initial begin
        logic [7:0] got;
        logic [7:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = lif.lfsr_out;
                obs_log.push_back(got);
                check("word", got, exp);
                tests++;
                if ($isunknown(got)) begin
                    failed++;
                    $display("FAIL xz: got %02h expected no X/Z", got);
                end else begin
`ifdef LFSR_PARITY_ODD_EN
                    check_int("parity_odd", $countones(got) % 2, 1);
`else
                    check_int("parity_even", $countones(got) % 2, 0);
`endif
                end
            end
        end
    end

    // Driver.
    initial begin
        int lit [14];
        int start;
        int distinct;
        int dup;
        bit seen [128];

        lit = '{'h02, 'h04, 'h08, 'h10, 'h20, 'h41, 'h03, 'h06, 'h0C, 'h18, 'h30, 'h61, 'h42, 'h05};
        rst = 1'b1;
        m_state = 0;

        // Reset held for two edges.
        step(1'b1);
        step(1'b1);

        // 127 edges after release: first 14 against the literal sequence, then the model.
        start = pushes;
        for (int i = 0; i < 14; i++) step_lit(lit[i]);
        for (int i = 14; i < 127; i++) step(1'b0);
        @(posedge clk);
        #2;

        // Full period coverage over the 127 samples just observed.
        distinct = 0;
        dup = 0;
        for (int k = 0; k < 128; k++) seen[k] = 1'b0;
        for (int k = 0; k < 127; k++) begin
            int v;
            v = int'(obs_log[start + k][6:0]);
            if (seen[v]) dup++;
            else distinct++;
            seen[v] = 1'b1;
        end
        check_int("period_distinct", distinct, 127);
        check_int("period_dup", dup, 0);
        check_int("zero_never_seen", int'(seen[0]), 0);
        check_int("period_return", int'(obs_log[start + 126][6:0]), 1);

        // 100 random cycles with sporadic resets, plus a forced one-cycle reset at cycle 40.
        for (int i = 0; i < 100; i++) begin
            step((i == 40) || ($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 3; i++) step(1'b0);

        // Lock-up recovery: deposit zero into the state, then one normal edge.
        @(negedge clk);
        rst = 1'b0;
        force dut.u_core.state = 7'h00;
        #1;
        release dut.u_core.state;
        m_state = model_next(0, 1'b0);
        exp_q.push_back(model_word(m_state));
        pushes++;
        for (int i = 0; i < 5; i++) step(1'b0);

        // Reset held for several cycles, then resume.
        for (int i = 0; i < 4; i++) step(1'b1);
        for (int i = 0; i < 4; i++) step(1'b0);

        @(posedge clk);
        #2;
        check_int("queue_drained", exp_q.size(), 0);
        check_int("samples_seen", obs_log.size(), pushes);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
